sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter and access sequencer for the single external 16-bit SRAM. It shares the SRAM between the instruction-fetch port (read-only) and the data port (read/write). It grants one access at a time round-robin and drives the SRAM address, enable and tri-state data lines in the fixed two-phase read/write sequence. It sits between the CPU memory stages and the board SRAM pins.

## Interface
Parameters:
- `ADDR_W`, 18: SRAM word-address width.
- `DATA_W`, 16: SRAM data width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `i_req`  in  1  instruction port request (read).
- `i_addr`  in  ADDR_W  instruction read address.
- `i_ack`  out  1  one-cycle pulse: instruction read complete, `rdata` valid.
- `d_req`  in  1  data port request.
- `d_we`  in  1  data port: 1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data port address.
- `d_wdata`  in  DATA_W  data port write data.
- `d_ack`  out  1  one-cycle pulse: data access complete, `rdata` valid if read.
- `rdata`  out  DATA_W  last read result, shared by both ports.
- `addr_o`  out  ADDR_W  SRAM address.
- `wr_en_o`  out  1  SRAM write enable, active high.
- `rd_en_o`  out  1  SRAM read enable, active high.
- `data_io`  inout  DATA_W  SRAM data bus. Driven with the latched write data while `wr_en_o`=1, otherwise high-Z.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE / ACK to ACCESS occurs on an edge where at least one `req` is high:
  - Latch the winner's address into `addr_o` and its write data.
  - Assert `rd_en_o`, or `wr_en_o` if the data port wins with `d_we`=1.
  - Record the winner in `last_gnt`.
- Arbitration when only one request is high: that port wins.
- Arbitration when both are high: the port not in `last_gnt` wins (strict alternation). `last_gnt` resets to data, so the first tie goes to instruction.
- ACCESS to ACK (unconditional, next edge):
  - Deassert both enables.
  - For a read, capture `data_io` into `rdata`.
  - Assert the winner's ack; it is high for exactly the ACK cycle.
- ACK to IDLE occurs when no `req` is high.
- Requests are sampled only on edges taken from IDLE or ACK. `req` and address changes during ACCESS are ignored.
- Requester rule: hold `req` and its address/data stable until its ack. During the ack cycle, either drop `req` or present the next request. A `req` still high at the edge ending ACK is a new access.
- `rdata` holds its value until the next read completes; writes do not change it.
- `wr_en_o` and `rd_en_o` are never both high.
- `data_io` is driven only while `wr_en_o`=1.
- Reset, asserted at any time including mid-access:
  - Immediately forces IDLE.
  - Clears both enables (bus to high-Z), `addr_o`=0, `i_ack`=`d_ack`=0, `rdata`=0, `last_gnt`=data.
  - An interrupted access produces no ack and must be reissued.

## Timing
- Latency: request seen at edge T0 → enable high T0..T1 → ack high T1..T2.
- Read data is sampled at T1.
- Throughput: one access per 2 cycles sustained (ACK → ACCESS directly).
- Both ports requesting continuously: grants alternate I, D, I, D…, each port getting one access per 4 cycles.
- All outputs are registered. No combinational path from any input to any output except `data_io` enable from the `wr_en_o` register.

## Test plan
- Reset mid-write:
  - Stimulus: assert `rst`=0 while `wr_en_o`=1.
  - Required: `wr_en_o`=0 and `data_io`=Z asynchronously. No `d_ack`. After release, state IDLE, `addr_o`=0.
- Single write then read:
  - Stimulus: data write addr 0x00012 data 0xBEEF, then data read of 0x00012 from the SRAM model.
  - Required: `wr_en_o` high for exactly one cycle with `data_io`=0xBEEF. `d_ack` follows one cycle later. The read returns `rdata`=0xBEEF with `d_ack` on the 2nd cycle.
- Simultaneous requests after reset:
  - Stimulus: `i_req` and `d_req` both high (i addr 0x00100, d addr 0x3FFFF).
  - Required: instruction granted first (`addr_o`=0x00100), data second (`addr_o`=0x3FFFF). Exactly one ack per access.
- Sustained contention:
  - Stimulus: both `req` held high for 16 cycles.
  - Required: alternating grants, 8 acks total (4 each). Never both enables high.
- Back-to-back single port:
  - Stimulus: `i_req` held high across ack with addresses 0,1,2,3.
  - Required: 4 reads in 8 cycles, `i_ack` pulsing every other cycle, `rdata` matches the model.
- Request change during ACCESS:
  - Stimulus: change `d_addr` while in ACCESS.
  - Required: `addr_o` keeps the latched value until the next grant.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin sharer of one external SRAM between instruction (read) and data (read/write) ports.
// Latency: enable for one cycle after grant, ack the cycle after; no stall beyond the 2-cycle access.
module sram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_en_o,
  output logic              rd_en_o,
  inout  wire  [DATA_W-1:0] data_io
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_take;
  logic                w_pick_d;
  logic                r_last_gnt_d;
  logic                r_gnt_d;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_wr_en;
  logic                r_rd_en;
  logic                r_i_ack;
  logic                r_d_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ties go to whichever port did not win last time.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_pick_d    = d_req && (!i_req || !r_last_gnt_d);
    case (r_state)
      S_IDLE, S_ACK: begin
        if (i_req || d_req) begin
          w_take      = 1'b1;
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: w_state_nxt = S_ACK;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_gnt_d <= 1'b1;
      r_gnt_d      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_i_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (w_take) begin
        r_gnt_d      <= w_pick_d;
        r_last_gnt_d <= w_pick_d;
        r_addr       <= w_pick_d ? d_addr : i_addr;
        r_wdata      <= d_wdata;
        r_wr_en      <= w_pick_d && d_we;
        r_rd_en      <= !(w_pick_d && d_we);
      end else if (r_state == S_ACCESS) begin
        r_wr_en <= 1'b0;
        r_rd_en <= 1'b0;
        if (r_rd_en) begin
          r_rdata <= data_io;
        end
        r_i_ack <= !r_gnt_d;
        r_d_ack <= r_gnt_d;
      end
    end
  end

  assign data_io = r_wr_en ? r_wdata : {DATA_W{1'bz}};
  assign addr_o  = r_addr;
  assign wr_en_o = r_wr_en;
  assign rd_en_o = r_rd_en;
  assign rdata   = r_rdata;
  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM model and an in-order grant/ack scoreboard.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_ack, d_ack, wr_en_o, rd_en_o;
  logic [DW-1:0] rdata;
  logic [AW-1:0] addr_o;
  wire  [DW-1:0] data_io;

  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  typedef struct packed {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_iack = 0;
  int   n_dack = 0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .addr_o(addr_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .data_io(data_io)
  );

  always #5 clk = ~clk;

  assign data_io = rd_en_o ? mem[addr_o[9:0]] : {DW{1'bz}};

  function automatic logic [DW-1:0] pat(input int k);
    return DW'(k * 37 + 4096);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_d, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w);
    exp_t e;
    e.is_d  = is_d;
    e.we    = we;
    e.addr  = a;
    e.wdata = w;
    sb.push_back(e);
  endtask

  task automatic single(input logic is_d, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] w, input string tag);
    int cyc;
    logic got;
    push(is_d, we, a, w);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      tick();
      cyc++;
      got = is_d ? d_ack : i_ack;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd2);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // SRAM model: write lands on the edge that ends the write-enable cycle.
  initial begin : sram_model
    for (int k = 0; k < 1024; k++) mem[k] = pat(k);
    forever begin
      @(posedge clk);
      if (wr_en_o) mem[addr_o[9:0]] = data_io;
    end
  end

  initial begin : monitor
    exp_t e;
    logic prev_acc;
    prev_acc = 1'b0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = pat(k);
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_acc = 1'b0;
      end else begin
        if (i_ack) n_iack++;
        if (d_ack) n_dack++;
        chk("enables_exclusive", 32'(wr_en_o & rd_en_o), 32'd0);
        if (prev_acc) begin
          chk("ack_after_access", 32'(i_ack ^ d_ack), 32'd1);
          chk("enables_low_in_ack", 32'({wr_en_o, rd_en_o}), 32'd0);
          chk("ack_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ack_port", 32'({i_ack, d_ack}), e.is_d ? 32'd1 : 32'd2);
            if (e.we) ref_mem[e.addr[9:0]] = e.wdata;
            else chk("rdata", 32'(rdata), 32'(ref_mem[e.addr[9:0]]));
          end
        end else begin
          chk("no_spurious_ack", 32'({i_ack, d_ack}), 32'd0);
        end
        if (wr_en_o || rd_en_o) begin
          chk("grant_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb[0];
            chk("grant_addr", 32'(addr_o), 32'(e.addr));
            chk("grant_we", 32'(wr_en_o), 32'(e.we));
            if (e.we) chk("write_bus", 32'(data_io), 32'(e.wdata));
          end
          prev_acc = 1'b1;
        end else begin
          prev_acc = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n, cyc, base_i, base_d;
    logic [3:0] seq;

    #2 rst = 1'b0;
    #3;
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_rd_en", 32'(rd_en_o), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    single(1'b1, 1'b1, 18'h00012, 16'hBEEF, "wr");
    single(1'b1, 1'b0, 18'h00012, 16'h0000, "rd");
    chk("rd_beef", 32'(rdata), 32'h0000BEEF);
    tick();

    // Fresh reset so the first tie must go to the instruction port.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst2_rdata", 32'(rdata), 32'd0);
    tick();
    push(1'b0, 1'b0, 18'h00100, 16'h0);
    push(1'b1, 1'b0, 18'h3FFFF, 16'h0);
    i_req = 1'b1; i_addr = 18'h00100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 18'h3FFFF;
    n = 0; cyc = 0; seq = '0;
    while ((i_req || d_req) && cyc < 12) begin
      tick();
      cyc++;
      if (i_ack || d_ack) begin
        seq = {seq[2:0], d_ack};
        n++;
      end
      if (i_ack) i_req = 1'b0;
      if (d_ack) d_req = 1'b0;
    end
    chk("tie_order", 32'(seq), 32'd1);
    chk("tie_acks", 32'(n), 32'd2);
    chk("tie_cycles", 32'(cyc), 32'd4);
    tick();

    for (int k = 0; k < 4; k++) begin
      push(1'b0, 1'b0, 18'h00200, 16'h0);
      push(1'b1, 1'b1, 18'h00200, 16'h5A5A);
    end
    base_i = n_iack;
    base_d = n_dack;
    i_req = 1'b1; i_addr = 18'h00200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 18'h00200; d_wdata = 16'h5A5A;
    repeat (16) tick();
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    chk("cont_iacks", 32'(n_iack - base_i), 32'd4);
    chk("cont_dacks", 32'(n_dack - base_d), 32'd4);
    chk("cont_drained", 32'(sb.size()), 32'd0);

    for (int k = 0; k < 4; k++) push(1'b0, 1'b0, AW'(k), 16'h0);
    i_req = 1'b1; i_addr = '0;
    n = 0; cyc = 0;
    while (i_req && cyc < 20) begin
      tick();
      cyc++;
      if (i_ack) begin
        chk("b2b_rdata", 32'(rdata), 32'(pat(n)));
        n++;
        if (n == 4) i_req = 1'b0;
        else i_addr = AW'(n);
      end
    end
    chk("b2b_acks", 32'(n), 32'd4);
    chk("b2b_cycles", 32'(cyc), 32'd8);
    tick();

    push(1'b1, 1'b0, 18'h00055, 16'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 18'h00055;
    tick();
    chk("hold_in_access", 32'(rd_en_o), 32'd1);
    d_addr = 18'h00066;
    tick();
    chk("hold_ack", 32'(d_ack), 32'd1);
    chk("hold_addr_ack", 32'(addr_o), 32'h55);
    d_req = 1'b0;
    tick();
    tick();
    chk("hold_addr_idle", 32'(addr_o), 32'h55);

    push(1'b1, 1'b1, 18'h00030, 16'h1111);
    d_req = 1'b1; d_we = 1'b1; d_addr = 18'h00030; d_wdata = 16'h1111;
    tick();
    chk("mw_wr_en", 32'(wr_en_o), 32'd1);
    chk("mw_bus", 32'(data_io), 32'h1111);
    #1 rst = 1'b0;
    #1;
    chk("mw_wr_en_async", 32'(wr_en_o), 32'd0);
    chk("mw_rd_en_async", 32'(rd_en_o), 32'd0);
    chk("mw_addr_async", 32'(addr_o), 32'd0);
    sb.delete();
    d_req = 1'b0;
    d_we = 1'b0;
    repeat (3) begin
      tick();
      chk("mw_no_ack", 32'({i_ack, d_ack}), 32'd0);
    end
    rst = 1'b1;
    tick();
    chk("mw_idle_addr", 32'(addr_o), 32'd0);
    chk("mw_idle_en", 32'({wr_en_o, rd_en_o}), 32'd0);
    single(1'b1, 1'b0, 18'h00030, 16'h0, "mw_reread");
    chk("mw_not_written", 32'(rdata), 32'(pat(32'h30)));

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
